// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI responder clocked by the system clock with synchronized SCLK/SS/MOSI.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN: MISO is high-Z whenever the frame FSM is not in SHIFT.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // tx_load, rx_valid and rx_abort are single-cycle strobes with no back-pressure:
  // a consumer must take rx_data in the cycle rx_valid is high (it then holds anyway).
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_abort,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  SS
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_d1_q;
  logic                   ss_d1_q;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_abort_q, rx_abort_d;
  logic                  tx_load_q, tx_load_d;

  // SYNC_STAGES must be at least 2; all three chains share one depth so MOSI stays aligned to SCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d1_q   <= 1'b0;
      ss_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_d1_q   <= sclk_s;
      ss_d1_q     <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign ss_rise   = ss_s & ~ss_d1_q;
  assign ss_fall   = ~ss_s & ss_d1_q;
  assign rx_next   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      bit_cnt_q  <= '0;
      arm_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_abort_q <= rx_abort_d;
      tx_load_q  <= tx_load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    arm_cnt_d  = arm_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_abort_d = 1'b0;
    tx_load_d  = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        // The SS chain resets to "high", so ss_s is only trusted once the pin has propagated through.
        if (arm_cnt_q != ARM_DONE) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end else if (ss_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ss_fall) begin
          tx_shift_d = tx_data;
          tx_load_d  = 1'b1;
          miso_d     = tx_data[DATA_WIDTH-1];
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
          if (bit_cnt_q != '0) begin
            rx_abort_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            tx_shift_d = tx_data;
            tx_load_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          miso_d = tx_shift_q[LAST_BIT - bit_cnt_q];
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_abort = rx_abort_q;
  assign busy     = busy_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = (state_q == ST_SHIFT) ? miso_q : 1'bz;
`else
  assign MISO = miso_q;
`endif

endmodule
